// File: rtl/code_sequencer_pkg.sv
// Shared types and helpers for the access-code sequencer.
package code_sequencer_pkg;

    localparam int SYM_W = 3;
    localparam int KEY_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        UNLOCKED = 3'd2,
        PENALTY  = 3'd3,
        ALARM    = 3'd4
    } state_e;

    function automatic logic popcount_is_one(input logic [KEY_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < KEY_W; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/code_sequencer_key_event_detect.sv
// Turns debounced key levels into single-cycle press events with a symbol index.
module key_event_detect
    import code_sequencer_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEY_W-1:0] keys_i,
    output logic             event_valid_o,
    output logic             event_invalid_o,
    output logic [SYM_W-1:0] event_sym_o
);

    logic [KEY_W-1:0] prev_keys_q;
    logic [KEY_W-1:0] rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) prev_keys_q <= '0;
        else       prev_keys_q <= keys_i;
    end

    assign rise            = keys_i & ~prev_keys_q;
    assign event_valid_o   = popcount_is_one(rise);
    assign event_invalid_o = (|rise) & ~popcount_is_one(rise);

    // Lowest set bit wins; the symbol is irrelevant for invalid events.
    always_comb begin
        event_sym_o = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (rise[i]) event_sym_o = SYM_W'(i);
        end
    end

endmodule

// File: rtl/code_sequencer.sv
// Access-code sequencer: constant-time code compare, retry limit, penalty and latched alarm.
// Inter-key timeout is built only when CODE_SEQ_TIMEOUT_EN is defined.
//
//  state    | meaning
//  IDLE     | waiting for the first press
//  ENTRY    | collecting symbols, evaluating once all slots are filled
//  UNLOCKED | grant held for UNLOCK_CYCLES
//  PENALTY  | hold-off after a wrong code
//  ALARM    | terminal until reset
module code_sequencer
    import code_sequencer_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int ENTRY_TIMEOUT  = 25_000_000,
    parameter int PENALTY_CYCLES = 25_000_000,
    parameter int UNLOCK_CYCLES  = 50_000_000
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [KEY_W-1:0]          keys_in,
    input  logic [SYM_W*CODE_LEN-1:0] code_key,
    output logic                      unlocked,
    output logic                      alarm,
    output logic [2:0]                attempts_left,
    output logic [2:0]                fsm_state
);

    localparam int IDX_W   = $clog2(CODE_LEN + 1);
    localparam int CNT_MAX = (UNLOCK_CYCLES > PENALTY_CYCLES) ? UNLOCK_CYCLES : PENALTY_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
`ifdef CODE_SEQ_TIMEOUT_EN
    localparam int TMO_W   = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;
`endif

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mism_q, mism_d;
    logic [2:0]         att_q, att_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef CODE_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0]   tmo_q, tmo_d;
`endif

    logic               ev_valid, ev_invalid, ev_any, fail;
    logic [SYM_W-1:0]   ev_sym, exp_sym;

    key_event_detect u_event (
        .clk_i           (clk),
        .rst_i           (rst),
        .keys_i          (keys_in),
        .event_valid_o   (ev_valid),
        .event_invalid_o (ev_invalid),
        .event_sym_o     (ev_sym)
    );

    assign ev_any = ev_valid | ev_invalid;

    always_comb begin
        exp_sym = code_key[SYM_W-1:0];
        for (int k = 1; k < CODE_LEN; k++) begin
            if (idx_q == IDX_W'(k)) exp_sym = code_key[k*SYM_W +: SYM_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mism_q  <= 1'b0;
            att_q   <= 3'(MAX_ATTEMPTS);
            cnt_q   <= '0;
`ifdef CODE_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mism_q  <= mism_d;
            att_q   <= att_d;
            cnt_q   <= cnt_d;
`ifdef CODE_SEQ_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mism_d  = mism_q;
        att_d   = att_q;
        cnt_d   = '0;
`ifdef CODE_SEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
        fail    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ev_any) begin
                    state_d = ENTRY;
                    idx_d   = IDX_W'(1);
                    mism_d  = ev_invalid | (ev_sym != code_key[SYM_W-1:0]);
                end
            end
            ENTRY: begin
                // A wrong symbol only sets the sticky flag; entry always runs to the last slot.
                if (idx_q == IDX_W'(CODE_LEN)) begin
                    if (!mism_q) begin
                        state_d = UNLOCKED;
                        att_d   = 3'(MAX_ATTEMPTS);
                        idx_d   = '0;
                        mism_d  = 1'b0;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (ev_any) begin
                    idx_d  = idx_q + 1'b1;
                    mism_d = mism_q | ev_invalid | (ev_sym != exp_sym);
                end
`ifdef CODE_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_W'(ENTRY_TIMEOUT - 1)) begin
                    fail = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
                if (fail) begin
                    idx_d  = '0;
                    mism_d = 1'b0;
                    if (att_q > 3'd1) begin
                        att_d   = att_q - 3'd1;
                        state_d = PENALTY;
                    end else begin
                        att_d   = 3'd0;
                        state_d = ALARM;
                    end
                end
            end
            UNLOCKED: begin
                if (cnt_q == CNT_W'(UNLOCK_CYCLES - 1)) state_d = IDLE;
                else                                     cnt_d   = cnt_q + 1'b1;
            end
            PENALTY: begin
                if (cnt_q == CNT_W'(PENALTY_CYCLES - 1)) state_d = IDLE;
                else                                      cnt_d   = cnt_q + 1'b1;
            end
            ALARM: begin
            end
            default: state_d = IDLE;
        endcase
    end

    assign unlocked      = (state_q == UNLOCKED);
    assign alarm         = (state_q == ALARM);
    assign attempts_left = att_q;
    assign fsm_state     = state_q;

endmodule
